// File: rtl/fft_agu.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT; optional FFT_INV_EN adds conjugate twiddles.
// Latency: pair 0 presented 2 cycles after start; BTF_LAT+1 idle cycles after every stage.
// Backpressure: vld & !ready_in freezes all outputs and counters; the drain counter ignores ready_in.
module fft_agu #(
    parameter int LOG2N   = 4,
    parameter int BTF_LAT = 2,
    parameter     TWD_FILE = "twiddle.hex"
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        ready_in,
`ifdef FFT_INV_EN
    input  logic                                        inv,
`endif
    output logic                                        busy,
    output logic                                        done,
    output logic                                        vld,
    output logic [LOG2N-1:0]                            addr_a,
    output logic [LOG2N-1:0]                            addr_b,
    output logic [31:0]                                 wn,
    output logic [((LOG2N > 2) ? $clog2(LOG2N) : 1)-1:0] stage,
    output logic                                        last
);
    localparam int N  = 1 << LOG2N;
    localparam int HN = N / 2;
    localparam int KW = LOG2N - 1;
    localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;
    localparam int CW = (BTF_LAT < 1) ? 1 : $clog2(BTF_LAT + 1);

    if (LOG2N < 2 || LOG2N > 10 || $bits(TWD_FILE) == 0) begin : g_bad_cfg
        $error("fft_agu: LOG2N must be in 2..10");
    end

    // Table is generated at elaboration with the same formula used to build TWD_FILE images.
    function automatic logic [31:0] twd(input int t);
        real ang;
        int  ci;
        int  si;
        ang = 2.0 * 3.14159265358979323846 * real'(t) / real'(N);
        ci  = int'(16384.0 * $cos(ang));
        si  = int'(-16384.0 * $sin(ang));
        return {si[15:0], ci[15:0]};
    endfunction

    logic [31:0] rom [HN];
    for (genvar t = 0; t < HN; t++) begin : g_rom
        assign rom[t] = twd(t);
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [SW-1:0]     s_q, s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, vld_q, vld_d, last_q, last_d;
    logic [LOG2N-1:0]  addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [31:0]       wn_q, wn_d;

    logic [KW-1:0]     ld_k;
    logic [SW-1:0]     ld_s;
    logic [LOG2N-1:0]  kx, half, j, pa, pb;
    logic [KW-1:0]     tidx;
    logic [31:0]       rom_w, twd_w;

    // Pair to present on the next load: successor in RUN, first pair of next stage in DRAIN.
    always_comb begin
        ld_k = k_q;
        ld_s = s_q;
        if (state_q == S_RUN && vld_q) begin
            ld_k = k_q + KW'(1);
        end
        if (state_q == S_DRAIN) begin
            ld_k = '0;
            ld_s = s_q + SW'(1);
        end
        kx   = {1'b0, ld_k};
        half = LOG2N'(1) << ld_s;
        j    = kx & (half - LOG2N'(1));
        pa   = (((kx >> ld_s) << ld_s) << 1) | j;
        pb   = pa | half;
        tidx = KW'(j << (KW - int'(ld_s)));
    end

    assign rom_w = rom[tidx];

`ifdef FFT_INV_EN
    logic inv_q, inv_d;
    assign twd_w = inv_q ? {16'd0 - rom_w[31:16], rom_w[15:0]} : rom_w;
`else
    assign twd_w = rom_w;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        vld_d    = vld_q;
        last_d   = last_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        wn_d     = wn_q;
`ifdef FFT_INV_EN
        inv_d    = inv_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    k_d     = '0;
                    s_d     = '0;
                    cnt_d   = '0;
`ifdef FFT_INV_EN
                    inv_d   = inv;
`endif
                end
            end
            S_RUN: begin
                if (!vld_q || ready_in) begin
                    if (vld_q && k_q == KW'(HN - 1)) begin
                        state_d = S_DRAIN;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        k_d      = ld_k;
                        vld_d    = 1'b1;
                        addr_a_d = pa;
                        addr_b_d = pb;
                        wn_d     = twd_w;
                        last_d   = (s_q == SW'(LOG2N - 1)) && (ld_k == KW'(HN - 1));
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q != CW'(BTF_LAT)) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (s_q == SW'(LOG2N - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = '0;
                    k_d     = '0;
                end else begin
                    state_d  = S_RUN;
                    s_d      = ld_s;
                    k_d      = ld_k;
                    vld_d    = 1'b1;
                    addr_a_d = pa;
                    addr_b_d = pb;
                    wn_d     = twd_w;
                    last_d   = (ld_s == SW'(LOG2N - 1)) && (HN == 1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            wn_q     <= '0;
`ifdef FFT_INV_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wn_q     <= wn_d;
`ifdef FFT_INV_EN
            inv_q    <= inv_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign vld    = vld_q;
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;
    assign wn     = wn_q;
    assign stage  = s_q;
    assign last   = last_q;
endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: DIT butterfly-order reference model, random and directed backpressure.
`timescale 1ns/1ps
module tb_fft_agu;
    localparam int LOG2N   = 4;
    localparam int BTF_LAT = 2;
    localparam int N       = 1 << LOG2N;
    localparam int HN      = N / 2;
    localparam int DR      = BTF_LAT + 1;
    localparam int SW      = (LOG2N > 2) ? $clog2(LOG2N) : 1;
    localparam int RUN_CYC = 1 + LOG2N * (HN + DR);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              ready_in = 1'b0;
`ifdef FFT_INV_EN
    logic              inv = 1'b0;
`endif
    logic              busy, done, vld, last;
    logic [LOG2N-1:0]  addr_a, addr_b;
    logic [31:0]       wn;
    logic [SW-1:0]     stage;

    fft_agu #(.LOG2N(LOG2N), .BTF_LAT(BTF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .ready_in(ready_in),
`ifdef FFT_INV_EN
        .inv(inv),
`endif
        .busy(busy), .done(done), .vld(vld), .addr_a(addr_a), .addr_b(addr_b),
        .wn(wn), .stage(stage), .last(last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        int          b;
        logic [31:0] w;
        int          s;
        bit          l;
    } pr_t;

    pr_t exp_q[$];
    pr_t obs_q[$];
    bit  vld_hist[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cyc, stall_cnt, hold_viol;
    logic busy_e0, vld_e0;

    function automatic logic [31:0] ref_twiddle(input int t, input bit conj);
        int c;
        int s;
        c = int'(16384.0 * $cos(2.0 * 3.14159265358979323846 * real'(t) / real'(N)));
        s = int'(-16384.0 * $sin(2.0 * 3.14159265358979323846 * real'(t) / real'(N)));
        if (conj) s = -s;
        return {s[15:0], c[15:0]};
    endfunction

    // Butterflies listed group by group, as a textbook DIT stage visits them.
    function automatic void build_model(input bit conj);
        pr_t e;
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            int span = 1 << s;
            for (int g = 0; g < N; g += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    e.a = g + j;
                    e.b = g + j + span;
                    e.w = ref_twiddle(j * (N / (2 * span)), conj);
                    e.s = s;
                    e.l = (s == LOG2N - 1) && (g + 2 * span == N) && (j == span - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    // mode 0: always ready; 1: random ready and stray start pulses; 2: 5-cycle stall on stage-0 pair (6,7)
    task automatic run_seq(input int mode, input bit conj);
        int   stall_left;
        bit   stall_used, prev_st;
        logic pv, pl;
        logic [LOG2N-1:0] pa, pb;
        logic [31:0] pw;
        logic [SW-1:0] ps;
        pr_t o;
        obs_q.delete();
        vld_hist.delete();
        done_cyc = -1; stall_cnt = 0; hold_viol = 0;
        stall_left = 0; stall_used = 0; prev_st = 0;
        pv = 0; pl = 0; pa = '0; pb = '0; pw = '0; ps = '0;
        @(negedge clk);
        start = 1'b1; ready_in = 1'b1;
`ifdef FFT_INV_EN
        inv = conj;
`endif
        @(negedge clk);
        start = 1'b0;
        busy_e0 = busy; vld_e0 = vld;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (prev_st && (vld !== pv || addr_a !== pa || addr_b !== pb || wn !== pw
                            || stage !== ps || last !== pl)) hold_viol++;
            vld_hist.push_back(vld === 1'b1);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            ready_in = 1'b1;
            if (mode == 1) begin
                ready_in = ($urandom_range(0, 3) != 0);
                start = (busy === 1'b1) && ($urandom_range(0, 7) == 0);
            end
            if (mode == 2) begin
                if (vld && stage == 0 && addr_a == 6 && !stall_used) begin
                    stall_used = 1; stall_left = 5;
                end
                if (stall_left > 0) begin
                    ready_in = 1'b0; stall_left--;
                end
            end
            prev_st = vld && !ready_in;
            if (prev_st) stall_cnt++;
            pv = vld; pa = addr_a; pb = addr_b; pw = wn; ps = stage; pl = last;
            if (vld && ready_in) begin
                o.a = int'(addr_a); o.b = int'(addr_b); o.w = wn; o.s = int'(stage); o.l = last;
                obs_q.push_back(o);
            end
        end
        start = 1'b0; ready_in = 1'b1;
`ifdef FFT_INV_EN
        inv = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vld); end
        n_cmp++; if (addr_a !== '0 || addr_b !== '0) begin
            n_bad++; $display("FAIL reset_addr got a=%0d b=%0d want 0 0", addr_a, addr_b); end
        n_cmp++; if (wn !== 32'h0) begin n_bad++; $display("FAIL reset_wn got %h want 0", wn); end
        n_cmp++; if (stage !== '0 || last !== 1'b0) begin
            n_bad++; $display("FAIL reset_stage_last got %0d/%b want 0/0", stage, last); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_forward_run();
        int nl, vb, idx;
        build_model(1'b0);
        run_seq(0, 1'b0);
        n_cmp++; if (busy_e0 !== 1'b1 || vld_e0 !== 1'b0) begin
            n_bad++; $display("FAIL fwd_after_e0 got busy=%b vld=%b want 1 0", busy_e0, vld_e0); end
        n_cmp++; if (obs_q.size() != LOG2N * HN) begin
            n_bad++; $display("FAIL fwd_count got %0d want %0d", obs_q.size(), LOG2N * HN); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size()) begin
                n_bad++; $display("FAIL fwd_pair[%0d] missing want a=%0d b=%0d", i, exp_q[i].a, exp_q[i].b);
            end else if (obs_q[i].a != exp_q[i].a || obs_q[i].b != exp_q[i].b || obs_q[i].w !== exp_q[i].w
                         || obs_q[i].s != exp_q[i].s || obs_q[i].l != exp_q[i].l) begin
                n_bad++;
                $display("FAIL fwd_pair[%0d] got a=%0d b=%0d w=%h s=%0d l=%b want a=%0d b=%0d w=%h s=%0d l=%b",
                         i, obs_q[i].a, obs_q[i].b, obs_q[i].w, obs_q[i].s, obs_q[i].l,
                         exp_q[i].a, exp_q[i].b, exp_q[i].w, exp_q[i].s, exp_q[i].l);
            end
        end
        n_cmp++;
        if (obs_q.size() < 26) begin
            n_bad++; $display("FAIL fwd_fixed too few pairs got %0d want 32", obs_q.size());
        end else if (obs_q[0].a != 0 || obs_q[0].b != 1 || obs_q[0].w !== 32'h0000_4000
                     || obs_q[18].a != 2 || obs_q[18].b != 6 || obs_q[18].w !== 32'hC000_0000
                     || obs_q[25].a != 1 || obs_q[25].b != 9 || obs_q[25].w !== 32'hE782_3B21) begin
            n_bad++;
            $display("FAIL fwd_fixed got p0=%0d,%0d,%h s2k2=%0d,%0d,%h s3k1=%0d,%0d,%h want 0,1,00004000 2,6,c0000000 1,9,e7823b21",
                     obs_q[0].a, obs_q[0].b, obs_q[0].w, obs_q[18].a, obs_q[18].b, obs_q[18].w,
                     obs_q[25].a, obs_q[25].b, obs_q[25].w);
        end
        nl = 0;
        foreach (obs_q[i]) if (obs_q[i].l) nl++;
        n_cmp++; if (nl != 1) begin n_bad++; $display("FAIL fwd_last_count got %0d want 1", nl); end
        n_cmp++; if (done_cyc != RUN_CYC) begin
            n_bad++; $display("FAIL fwd_done_cycle got E%0d want E%0d", done_cyc, RUN_CYC); end
        vb = 0; idx = 1;
        for (int s = 0; s < LOG2N; s++) begin
            for (int i = 0; i < HN + DR; i++) begin
                if (idx >= vld_hist.size() || vld_hist[idx] != (i < HN)) vb++;
                idx++;
            end
        end
        n_cmp++; if (vb != 0 || vld_hist.size() != RUN_CYC + 1 || vld_hist[0]) begin
            n_bad++; $display("FAIL fwd_vld_pattern got %0d bad cycles len %0d want 0 len %0d", vb, vld_hist.size(), RUN_CYC + 1); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fwd_busy_at_done got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL fwd_done_width got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_stall();
        int bad;
        build_model(1'b0);
        run_seq(2, 1'b0);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i].a != exp_q[i].a || obs_q[i].b != exp_q[i].b
                               || obs_q[i].w !== exp_q[i].w || obs_q[i].s != exp_q[i].s) bad++;
        n_cmp++; if (bad != 0 || obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL stall_sequence got %0d bad of %0d want 0 of %0d", bad, obs_q.size(), exp_q.size()); end
        n_cmp++; if (hold_viol != 0 || stall_cnt != 5) begin
            n_bad++; $display("FAIL stall_hold got %0d changes, %0d stalls want 0, 5", hold_viol, stall_cnt); end
        n_cmp++; if (done_cyc != RUN_CYC + 5) begin
            n_bad++; $display("FAIL stall_done_cycle got E%0d want E%0d", done_cyc, RUN_CYC + 5); end
    endtask

    task automatic test_random_backpressure();
        for (int r = 0; r < 3; r++) begin
            int bad;
            build_model(1'b0);
            run_seq(1, 1'b0);
            bad = 0;
            foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i].a != exp_q[i].a || obs_q[i].b != exp_q[i].b
                                   || obs_q[i].w !== exp_q[i].w || obs_q[i].l != exp_q[i].l) bad++;
            n_cmp++; if (bad != 0 || obs_q.size() != exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d_sequence got %0d bad, %0d pairs want 0, %0d", r, bad, obs_q.size(), exp_q.size()); end
            n_cmp++; if (hold_viol != 0) begin
                n_bad++; $display("FAIL rand%0d_hold got %0d changes want 0", r, hold_viol); end
            n_cmp++; if (done_cyc != RUN_CYC + stall_cnt) begin
                n_bad++; $display("FAIL rand%0d_done_cycle got E%0d want E%0d", r, done_cyc, RUN_CYC + stall_cnt); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit reached;
        int spurious;
        @(negedge clk);
        start = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            @(negedge clk);
            if (vld === 1'b1 && stage == 1 && addr_a == 4) reached = 1;
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL midrst_reach_stage1 got none want stage 1 pair (4,6)"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (vld !== 1'b0 || busy !== 1'b0 || addr_a !== '0 || addr_b !== '0 || wn !== 32'h0 || stage !== '0) begin
            n_bad++; $display("FAIL midrst_async got vld=%b busy=%b a=%0d b=%0d w=%h s=%0d want all 0",
                              vld, busy, addr_a, addr_b, wn, stage); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (60) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || vld !== 1'b0) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL midrst_quiet got %0d active cycles want 0", spurious); end
        build_model(1'b0);
        run_seq(0, 1'b0);
        n_cmp++; if (obs_q.size() != LOG2N * HN || obs_q[0].a != 0 || obs_q[0].b != 1 || obs_q[0].s != 0) begin
            n_bad++; $display("FAIL midrst_restart got %0d pairs first (%0d,%0d) want 32 first (0,1)",
                              obs_q.size(), obs_q.size() > 0 ? obs_q[0].a : -1, obs_q.size() > 0 ? obs_q[0].b : -1); end
        n_cmp++; if (done_cyc != RUN_CYC) begin
            n_bad++; $display("FAIL midrst_done_cycle got E%0d want E%0d", done_cyc, RUN_CYC); end
    endtask

`ifdef FFT_INV_EN
    task automatic test_inverse();
        int bad;
        build_model(1'b1);
        run_seq(0, 1'b1);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i].a != exp_q[i].a || obs_q[i].w !== exp_q[i].w) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL inv_sequence got %0d bad pairs want 0", bad); end
        n_cmp++; if (obs_q.size() < 26 || obs_q[25].w !== 32'h187E_3B21 || obs_q[0].w !== 32'h0000_4000) begin
            n_bad++; $display("FAIL inv_fixed got s3k1=%h s0=%h want 187e3b21 00004000",
                              obs_q.size() > 25 ? obs_q[25].w : 32'h0, obs_q.size() > 0 ? obs_q[0].w : 32'h0); end
        build_model(1'b0);
        run_seq(0, 1'b0);
        n_cmp++; if (obs_q.size() < 26 || obs_q[25].w !== 32'hE782_3B21) begin
            n_bad++; $display("FAIL inv_relatch got %h want e7823b21", obs_q.size() > 25 ? obs_q[25].w : 32'h0); end
    endtask
`endif

    initial begin
        test_reset();
        test_forward_run();
        test_stall();
        test_random_backpressure();
        test_reset_mid_run();
`ifdef FFT_INV_EN
        test_inverse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
